vlc_bit_packer: RTL

//  Packs the variable-length codewords produced by the Golomb-Rice/VLC stage into a

---
 rtl/vlc_bit_packer_if.sv | 28 ++
 rtl/vlc_bit_packer.sv | 108 ++++++++++
 2 files changed

// File: rtl/vlc_bit_packer_if.sv
// Handshake bundle between the VLC coder, the bit packer and the slice writer.
// master = the side that feeds codewords and consumes packed words.
interface vlc_bit_packer_if;
    logic        input_valid;
    logic        input_ready;
    logic [31:0] sum_n;
    logic [31:0] codeword_length;
    logic        flush_req;
    logic        output_valid;
    logic        output_ready;
    logic [31:0] out_word;
    logic [2:0]  out_bytes;
    logic        flush_done;
    logic [31:0] total_bits;
    logic        length_error;

    modport master (
        output input_valid, sum_n, codeword_length, flush_req, output_ready,
        input  input_ready, output_valid, out_word, out_bytes, flush_done,
               total_bits, length_error
    );

    modport slave (
        input  input_valid, sum_n, codeword_length, flush_req, output_ready,
        output input_ready, output_valid, out_word, out_bytes, flush_done,
               total_bits, length_error
    );
endinterface

// File: rtl/vlc_bit_packer.sv
// Packs right-aligned variable-length codewords into an MSB-first stream of 32-bit
// words; flush byte-aligns the slice tail and reports the slice length in bits.
module vlc_bit_packer #(
    parameter int MAX_CW_LEN = 32
) (
    input logic             clk,
    input logic             reset_n,
    vlc_bit_packer_if.slave bus
);
    typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

    state_t      state, state_n;
    logic [63:0] acc, acc_s, acc_n;
    logic [6:0]  bit_cnt, cnt_s, cnt_n;
    logic [6:0]  sh;
    logic [5:0]  len;
    logic [31:0] code_mask;
    logic [63:0] code64;
    logic        slot_free, accept, full_word, partial, len_over;

    logic        ov_q;
    logic [31:0] word_q;
    logic [2:0]  bytes_q;
    logic [31:0] total_q;
    logic        lerr_q;

    assign bus.input_ready  = (state == RUN) && (bit_cnt <= 7'd32);
    assign bus.flush_done   = (state == DONE);
    assign bus.output_valid = ov_q;
    assign bus.out_word     = word_q;
    assign bus.out_bytes    = bytes_q;
    assign bus.total_bits   = total_q;
    assign bus.length_error = lerr_q;

    assign slot_free = !ov_q || bus.output_ready;
    assign accept    = bus.input_valid && bus.input_ready;
    assign full_word = (bit_cnt >= 7'd32) && slot_free;
    assign partial   = (state == FLUSH) && (bit_cnt != 7'd0) && (bit_cnt < 7'd32) && slot_free;
    assign len_over  = bus.codeword_length > 32'(MAX_CW_LEN);

    // Extraction happens first so a same-cycle append lands behind the remaining bits.
    always_comb begin
        len       = len_over ? 6'(MAX_CW_LEN) : bus.codeword_length[5:0];
        code_mask = (len >= 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << len) - 32'd1);
        code64    = {32'd0, bus.sum_n & code_mask};
        acc_s     = acc;
        cnt_s     = bit_cnt;
        if (full_word) begin
            acc_s = acc << 32;
            cnt_s = bit_cnt - 7'd32;
        end else if (partial) begin
            acc_s = '0;
            cnt_s = '0;
        end
        sh    = 7'd64 - cnt_s - {1'b0, len};
        acc_n = acc_s;
        cnt_n = cnt_s;
        if (accept) begin
            acc_n = acc_s | (code64 << sh);
            cnt_n = cnt_s + {1'b0, len};
        end
        state_n = state;
        case (state)
            RUN: if (bus.flush_req) begin
                state_n = FLUSH;
                // padding bits are already zero in acc; only the count moves
                cnt_n   = (cnt_n + 7'd7) & 7'h78;
            end
            FLUSH: if ((bit_cnt == 7'd0) && slot_free) state_n = DONE;
            DONE:  state_n = RUN;
            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= RUN;
        else          state <= state_n;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            bit_cnt <= '0;
            ov_q    <= 1'b0;
            word_q  <= '0;
            bytes_q <= '0;
            total_q <= '0;
            lerr_q  <= 1'b0;
        end else begin
            acc     <= acc_n;
            bit_cnt <= cnt_n;
            if (full_word) begin
                word_q  <= acc[63:32];
                bytes_q <= 3'd4;
                ov_q    <= 1'b1;
            end else if (partial) begin
                word_q  <= acc[63:32];
                bytes_q <= bit_cnt[5:3];
                ov_q    <= 1'b1;
            end else if (bus.output_ready) begin
                ov_q    <= 1'b0;
            end
            if (state == DONE)  total_q <= '0;
            else if (accept)    total_q <= total_q + {26'd0, len};
            if (accept && len_over) lerr_q <= 1'b1;
        end
    end
endmodule
